// File: rtl/row_buff_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : row_buff_ctrl
// Purpose  : Two-requester read controller for an 8x8 row buffer. Arbitrates
//            between req0/req1 (round-robin), drives one-hot row/column
//            selects, waits LAT+1 cycles for the buffer output, then holds
//            the captured bit (and optionally byte) until the consumer
//            accepts it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LAT        : cycles from the select-driving cycle to valid row_buff data
//                (legal range 1..4)
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   req0_valid / req1_valid : requester has a pending read
//   req0_addr  / req1_addr  : read address, [5:3] row, [2:0] column
//   req0_ready / req1_ready : request accepted this cycle (combinational)
//   rb_row     : one-hot row select to row_buff (registered)
//   rb_col     : one-hot column select to row_buff (registered)
//   rb_bit     : bit output from row_buff
//   rb_byte    : byte output from row_buff
//   rsp_valid  : response available
//   rsp_ready  : consumer accepts the response
//   rsp_id     : requester that owns the response
//   rsp_bit    : bit that was read
//   rsp_byte   : byte that was read (only with ROW_BUFF_CTRL_BYTE_EN)
// Configuration macro
//   ROW_BUFF_CTRL_BYTE_EN : when defined, adds the rsp_byte response path.
// ============================================================================
module row_buff_ctrl #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [5:0] req0_addr,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [5:0] req1_addr,
    output logic       req1_ready,
    output logic [7:0] rb_row,
    output logic [7:0] rb_col,
    input  logic       rb_bit,
    input  logic [7:0] rb_byte,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic       rsp_bit
`ifdef ROW_BUFF_CTRL_BYTE_EN
    ,
    output logic [7:0] rsp_byte
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;        // WAIT down-counter, loaded with LAT on accept
    logic        last_q;       // id of the requester granted last
    logic        id_q;
    logic [7:0]  rb_row_q;
    logic [7:0]  rb_col_q;
    logic        rsp_valid_q;
    logic        rsp_bit_q;

    logic        grant_any_d;
    logic        grant_id_d;
    logic [5:0]  grant_addr_d;

    // Grant is combinational in IDLE. It is gated with rst so that no ready
    // pulse is seen while reset is held, even though state already reads IDLE.
    always_comb begin
        grant_any_d = 1'b0;
        grant_id_d  = 1'b0;
        if ((state_q == S_IDLE) && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_any_d = 1'b1;
                grant_id_d  = ~last_q;
            end else if (req0_valid) begin
                grant_any_d = 1'b1;
                grant_id_d  = 1'b0;
            end else if (req1_valid) begin
                grant_any_d = 1'b1;
                grant_id_d  = 1'b1;
            end
        end
    end

    assign grant_addr_d = grant_id_d ? req1_addr : req0_addr;
    assign req0_ready   = grant_any_d & ~grant_id_d;
    assign req1_ready   = grant_any_d &  grant_id_d;

`ifdef ROW_BUFF_CTRL_BYTE_EN
    logic [7:0] rsp_byte_q;
`else
    // rb_byte has no consumer in this build.
    logic unused_rb_byte;
    assign unused_rb_byte = ^rb_byte;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            last_q      <= 1'b1;   // makes req0 the first winner on a collision
            id_q        <= 1'b0;
            rb_row_q    <= 8'h00;
            rb_col_q    <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
`ifdef ROW_BUFF_CTRL_BYTE_EN
            rsp_byte_q  <= 8'h00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any_d) begin
                        id_q     <= grant_id_d;
                        rb_row_q <= 8'h01 << grant_addr_d[5:3];
                        rb_col_q <= 8'h01 << grant_addr_d[2:0];
                        cnt_q    <= 3'(LAT);
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // LAT+1 WAIT cycles: counter walks LAT..0, capture at 0.
                    if (cnt_q == 3'd0) begin
                        rsp_bit_q   <= rb_bit;
`ifdef ROW_BUFF_CTRL_BYTE_EN
                        rsp_byte_q  <= rb_byte;
`endif
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rb_row_q    <= 8'h00;
                        rb_col_q    <= 8'h00;
                        last_q      <= id_q;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    rb_row_q    <= 8'h00;
                    rb_col_q    <= 8'h00;
                end
            endcase
        end
    end

    assign rb_row    = rb_row_q;
    assign rb_col    = rb_col_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_bit   = rsp_bit_q;
`ifdef ROW_BUFF_CTRL_BYTE_EN
    assign rsp_byte  = rsp_byte_q;
`endif

endmodule
`default_nettype wire

// File: doc/row_buff_ctrl.md
ROW_BUFF_CTRL -- requirements
Module: row_buff_ctrl

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `rst`; reset is asynchronous and active-high.
REQ-002 Parameter LAT, default 1, SHALL be the number of cycles from the select-driving cycle to the cycle in which row_buff output is valid; the legal range is 1..4.
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester N has a pending read.
REQ-006 req0_addr / req1_addr  input  6  read address; [5:3] is the row index, [2:0] is the column index.
REQ-007 req0_ready / req1_ready  output  1  request accepted in this cycle.
REQ-008 rb_row  output  8  one-hot row select to row_buff.
REQ-009 rb_col  output  8  one-hot column select to row_buff.
REQ-010 rb_bit  input  1  bit output from row_buff.
REQ-011 rb_byte  input  8  byte output from row_buff.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  1  index of the requester that owns the response.
REQ-015 rsp_bit  output  1  bit that was read.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 In IDLE, if any reqN_valid is high, the block SHALL assert exactly one reqN_ready (the grant) combinationally in that cycle, capture the id and address, and go to WAIT.
REQ-018 Arbitration SHALL be round-robin.
  - If both requests are valid, the requester not granted last SHALL win.
  - If one request is valid, that requester SHALL win.
  - After reset, priority SHALL go to req0.
REQ-019 reqN_ready SHALL be low in every state except IDLE.
REQ-020 In WAIT and RESP:
  - rb_row SHALL equal 1<<addr[5:3].
  - rb_col SHALL equal 1<<addr[2:0].
  - Both SHALL be registered and held stable.
  - In IDLE both SHALL be 8'h00.
REQ-021 WAIT SHALL last LAT+1 cycles, counted by a down-counter loaded on accept.
REQ-022 On the last WAIT edge the block SHALL register rb_bit into rsp_bit (and rb_byte, see REQ-031) and move to RESP.
REQ-023 Latency: for an accept in cycle T, rsp_valid SHALL first be high in cycle T+LAT+2.
REQ-024 In RESP, rsp_valid SHALL be high, and rsp_id, rsp_bit and rsp_byte SHALL be held stable until the cycle in which rsp_ready is high.
REQ-025 In the cycle where rsp_valid and rsp_ready are both high, the block SHALL return to IDLE on the next edge and update the round-robin pointer.
REQ-026 The block SHALL NOT accept a request in the same cycle as the response handshake; the minimum spacing between accepts is LAT+3 cycles.
REQ-027 Requests SHALL stay pending while not granted; the block SHALL NOT drop or reorder them.
REQ-028 rsp_bit SHALL equal bit (8*row+col) of the data word presented to row_buff.

Reset
REQ-029 When rst is asserted, regardless of state and mid-transaction, the block SHALL:
  - go to IDLE;
  - drive rb_row=0, rb_col=0, rsp_valid=0, rsp_id=0, rsp_bit=0, rsp_byte=0 and req0/1_ready=0 (with rst high);
  - clear the counter and set priority to req0;
  - discard any in-flight transaction without producing a response.
REQ-030 The first accept after rst deasserts SHALL be possible in the first cycle with rst low.

Configuration
REQ-031 The macro ROW_BUFF_CTRL_BYTE_EN SHALL control the byte response path.
  - Defined: output port rsp_byte (8 bits) exists and carries the captured rb_byte, under the same hold and reset rules as rsp_bit.
  - Undefined: rsp_byte and its register are absent, and rb_byte is present but unused.
  - In both cases all other behaviour SHALL be identical.

Verification
REQ-032 LAT=1, data=64'h0000_0000_0000_0100, req0 addr=6'o10 (row1, col0), rsp_ready=1 -> accept at T; rb_row=8'h02 and rb_col=8'h01 from T+1; rsp_valid at T+3 with rsp_bit=1 and rsp_id=0; rsp_byte=8'h01 with the macro defined.
REQ-033 Both requesters valid continuously, addrs 6'o77 and 6'o00, data=64'h8000_0000_0000_0000 -> grants alternate 0,1,0,1; rsp_bit alternates 1,0,1,0.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_valid stays high, outputs stable, no reqN_ready pulse; release -> IDLE next cycle.
REQ-035 LAT=3, single request -> rsp_valid at T+5; rb_row/rb_col stable T+1..T+5.
REQ-036 rst asserted in WAIT -> rb_row/rb_col go to 0 immediately; no rsp_valid afterwards; a following req1-only request is granted and a req0+req1 collision grants req0.
REQ-037 Reset and idle sweep -> all 64 addresses, each checked against REQ-028 with a random data word.
